// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial memory controller.
// Access sizes, controller states and the load extension helper.
package mem_ctrl_pkg;

    typedef logic [1:0] MemSelBus;

    localparam MemSelBus MEM_NOP  = 2'd0;
    localparam MemSelBus MEM_BYTE = 2'd1;
    localparam MemSelBus MEM_HALF = 2'd2;
    localparam MemSelBus MEM_WORD = 2'd3;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [7:0]  ZeroByte = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRD,
        ST_DWR,
        ST_IRD,
        ST_DONE
    } mem_state_e;

    // Index of the final byte of an access of the given size.
    function automatic logic [1:0] last_idx(input MemSelBus sel);
        logic [1:0] r;
        r = 2'd0;
        case (sel)
            MEM_HALF: r = 2'd1;
            MEM_WORD: r = 2'd3;
            default:  r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(
        input MemSelBus    sel,
        input logic        sign,
        input logic [31:0] w
    );
        logic [31:0] r;
        r = w;
        case (sel)
            MEM_BYTE: r = {{24{sign & w[7]}}, w[7:0]};
            MEM_HALF: r = {{16{sign & w[15]}}, w[15:0]};
            default:  r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating fetch and data ports
// onto a single 8-bit RAM with one-cycle read latency.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_cancel,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  MemSelBus              mem_sel,
    input  logic                  mem_sign,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din,
    output logic                  ram_wr,
    output logic                  busy
);

    mem_state_e  state;
    logic [1:0]  cnt;
    logic [1:0]  last;
    logic [31:0] asm_q;
    logic [31:0] asm_next;
    logic [1:0]  wr_idx;
    logic        fill;
    logic        armed;
    logic        is_fetch;
    MemSelBus    sel_q;
    logic        sign_q;
    logic        if_done_q;

    always_comb begin
        asm_next = asm_q;
        asm_next[{cnt, 3'b000} +: 8] = ram_din;
        wr_idx = cnt + 2'd1;
    end

    // A cancel arriving while the fetch result is on display hides it.
    assign if_done = if_done_q & ~if_cancel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 2'd0;
            last      <= 2'd0;
            asm_q     <= ZeroWord;
            fill      <= 1'b0;
            armed     <= 1'b0;
            is_fetch  <= 1'b0;
            sel_q     <= MEM_NOP;
            sign_q    <= 1'b0;
            if_done_q <= 1'b0;
            if_inst   <= ZeroWord;
            mem_done  <= 1'b0;
            mem_rdata <= ZeroWord;
            ram_addr  <= '0;
            ram_dout  <= ZeroByte;
            ram_wr    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            armed     <= 1'b1;
            if_done_q <= 1'b0;
            mem_done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (armed && mem_req) begin
                        is_fetch <= 1'b0;
                        sel_q    <= mem_sel;
                        sign_q   <= mem_sign;
                        last     <= last_idx(mem_sel);
                        cnt      <= 2'd0;
                        fill     <= 1'b0;
                        ram_addr <= mem_addr;
                        busy     <= 1'b1;
                        if (mem_sel == MEM_NOP) begin
                            state     <= ST_DONE;
                            mem_done  <= 1'b1;
                            mem_rdata <= ZeroWord;
                        end else if (mem_we) begin
                            state    <= ST_DWR;
                            asm_q    <= mem_wdata;
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                        end else begin
                            state <= ST_DRD;
                            asm_q <= ZeroWord;
                        end
                    end else if (armed && if_req) begin
                        state    <= ST_IRD;
                        is_fetch <= 1'b1;
                        last     <= 2'd3;
                        cnt      <= 2'd0;
                        fill     <= 1'b0;
                        asm_q    <= ZeroWord;
                        ram_addr <= if_addr;
                        busy     <= 1'b1;
                    end
                end
                ST_DRD, ST_IRD: begin
                    if (state == ST_IRD && if_cancel) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // Address runs one byte ahead of the capture.
                        ram_addr <= ram_addr + ADDR_WIDTH'(1);
                        fill     <= 1'b1;
                        if (fill) begin
                            asm_q <= asm_next;
                            if (cnt == last) begin
                                state <= ST_DONE;
                                if (is_fetch) begin
                                    if_inst   <= asm_next;
                                    if_done_q <= 1'b1;
                                end else begin
                                    mem_rdata <= load_ext(sel_q, sign_q, asm_next);
                                    mem_done  <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 2'd1;
                            end
                        end
                    end
                end
                ST_DWR: begin
                    if (cnt == last) begin
                        state    <= ST_DONE;
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                    end else begin
                        cnt      <= wr_idx;
                        ram_addr <= ram_addr + ADDR_WIDTH'(1);
                        ram_dout <= asm_q[{wr_idx, 3'b000} +: 8];
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    ram_wr <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of ram_addr and both request address ports.
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-low.
REQ-004 Port if_req  input  1  instruction-fetch word-read request; held high until if_done.
REQ-005 Port if_addr  input  ADDR_WIDTH  fetch byte address; stable while if_req is high.
REQ-006 Port if_cancel  input  1  abort the fetch in progress (branch taken).
REQ-007 Port if_done  output  1  one-cycle pulse; if_inst is valid in that cycle.
REQ-008 Port if_inst  output  32  fetched word, little-endian.
REQ-009 Port mem_req  input  1  data request from the MEM stage; held high until mem_done.
REQ-010 Port mem_we  input  1  1 = store, 0 = load.
REQ-011 Port mem_sel  input  MemSelBus  access size: MEM_NOP, MEM_BYTE, MEM_HALF or MEM_WORD.
REQ-012 Port mem_sign  input  1  sign-extend load result.
REQ-013 Port mem_addr  input  ADDR_WIDTH  data byte address.
REQ-014 Port mem_wdata  input  32  store data; byte i goes to address mem_addr+i.
REQ-015 Port mem_done  output  1  one-cycle pulse; mem_rdata is valid in that cycle for loads.
REQ-016 Port mem_rdata  output  32  load result, zero- or sign-extended.
REQ-017 Port ram_addr  output  ADDR_WIDTH  byte address to the RAM.
REQ-018 Port ram_dout  output  8  write byte to the RAM.
REQ-019 Port ram_din  input  8  read byte; valid one cycle after its address is presented.
REQ-020 Port ram_wr  output  1  RAM write strobe.
REQ-021 Port busy  output  1  high in every state except IDLE.

Function
REQ-022 States: IDLE, DRD (data read), DWR (data write), IRD (fetch read), DONE; all outputs are registered.
REQ-023 In IDLE, a request is accepted at a rising edge. If mem_req and if_req are both high, mem_req wins and the fetch waits.
REQ-024 Byte count N: 1 for MEM_BYTE, 2 for MEM_HALF, 4 for MEM_WORD and for every fetch.
REQ-025 Cycle 1 is the first cycle after the acceptance edge.
REQ-026 Reads: ram_addr = base+k in cycle k+1 for k = 0..N-1; ram_din is captured as byte k at the edge ending cycle k+2.
REQ-027 The read done pulse is asserted in cycle N+2. A word read therefore reports done in cycle 6.
REQ-028 Writes: in cycle k+1, ram_wr = 1, ram_addr = base+k and ram_dout = mem_wdata byte k; the done pulse is asserted in cycle N+1.
REQ-029 ram_wr is 0 in every cycle outside DWR.
REQ-030 Load extension: MEM_BYTE sign-extends bit 7 when mem_sign = 1; MEM_HALF sign-extends bit 15 when mem_sign = 1; otherwise zero-extend. MEM_WORD is not extended.
REQ-031 A mem_req with mem_sel = MEM_NOP goes directly to DONE: mem_done in cycle 1, mem_rdata = 0, no RAM access.
REQ-032 DONE lasts exactly one cycle and no request is accepted in it. The requester must drop req by the edge ending DONE. The next acceptance is at the edge ending cycle 1 of IDLE.
REQ-033 When if_cancel is high in IRD, the block moves to IDLE at the next edge with no if_done pulse.
REQ-034 When if_cancel is high in DONE for a fetch, if_done is suppressed in that cycle.
REQ-035 if_cancel is ignored in every other state.
REQ-036 Address arithmetic is base+k modulo 2^ADDR_WIDTH; wrap-around is permitted.
REQ-037 if_inst and mem_rdata hold their last values between done pulses.

Reset
REQ-038 While rst = 0 the block is asynchronously in IDLE and all outputs are forced: ram_wr = 0, ram_addr = 0, ram_dout = 0, if_done = 0, mem_done = 0, if_inst = 0, mem_rdata = 0, busy = 0.
REQ-039 Reset mid-operation abandons the transfer with no done pulse. A partially written store stays partial in the RAM.
REQ-040 After rst rises, the first request may be accepted at the second rising edge.

Structure
REQ-041 MEM_NOP, MEM_BYTE, MEM_HALF, MEM_WORD, MemSelBus, ZeroWord and ZeroByte are taken from the shared defines.v; the state encoding is also added there.
REQ-042 The block is a single module with no sub-module. One byte counter (0..3) and one 32-bit assembly register are shared by all states.

Verification
REQ-043 Word load: mem_req, mem_sel = WORD, addr 0x100, RAM bytes 11 22 33 44 -> mem_done in cycle 6, mem_rdata = 0x44332211.
REQ-044 Signed byte load: byte 0x80, mem_sign = 1 -> mem_rdata = 0xFFFFFF80; with mem_sign = 0 -> mem_rdata = 0x00000080.
REQ-045 Half store: mem_wdata = 0xAABBCCDD at 0x200 -> ram_wr in cycles 1-2 with (0x200, DD) then (0x201, CC); mem_done in cycle 3; RAM byte 0x202 unchanged.
REQ-046 Simultaneous if_req and mem_req (word load) -> data read completes first; the fetch starts at the edge after the following IDLE cycle; if_inst is correct.
REQ-047 if_cancel in cycle 3 of a fetch -> no if_done pulse; IDLE at the next edge; a new fetch at 0x40 returns the correct word.
REQ-048 rst = 0 in cycle 2 of a word store -> ram_wr = 0 immediately; only byte 0 is written; no mem_done pulse.
